// File: rtl/resp_frame_tx_pkg.sv
// Shared definitions for the host command link framing, used by the response
// transmitter and the command decoder.
package resp_frame_tx_pkg;

    localparam logic [7:0] HEAD_BYTE  = 8'hF0;
    localparam logic [7:0] LOCAL_ADDR = 8'h03;

    localparam logic [2:0] FUNC_RATE   = 3'd1;
    localparam logic [2:0] FUNC_POINT  = 3'd2;
    localparam logic [2:0] FUNC_RETURN = 3'd3;
    localparam logic [2:0] FUNC_ADDR   = 3'd4;

    localparam int         FRAME_LEN = 6;
    localparam logic [2:0] LAST_IDX  = 3'(FRAME_LEN - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Tail byte: XOR of address, function and both payload bytes (head excluded).
    function automatic logic [7:0] frame_checksum(input logic [7:0]  addr,
                                                  input logic [2:0]  func,
                                                  input logic [15:0] data);
        return addr ^ {5'b0, func} ^ data[15:8] ^ data[7:0];
    endfunction

endpackage

// File: rtl/resp_frame_tx_if.sv
// Request side and UART byte side of the response transmitter.
// master = the transmitter, slave = status logic / UART serialiser side.
interface resp_frame_tx_if;

    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_addr;
    logic [2:0]  req_func;
    logic [15:0] req_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        input  req_valid, req_addr, req_func, req_data, tx_ready,
        output req_ready, tx_data, tx_valid
    );

    modport slave (
        output req_valid, req_addr, req_func, req_data, tx_ready,
        input  req_ready, tx_data, tx_valid
    );

endinterface

// File: rtl/resp_frame_tx.sv
// Response-frame transmitter: latches a request and streams the 6-byte frame
// (head, addr, func, data hi, data lo, checksum) over a valid/ready byte link.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for a request; req_ready=1, tx_valid=0
// ST_SEND | presenting frame[idx]; abort with err after TIMEOUT stalls
module resp_frame_tx
    import resp_frame_tx_pkg::*;
#(
    parameter logic [7:0]  HEAD    = HEAD_BYTE,
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic            clk,
    input  logic            rst,
    resp_frame_tx_if.master link,
    output logic            busy,
    output logic            done,
    output logic            err
);

    state_t      state;
    logic [7:0]  frame [FRAME_LEN];
    logic [2:0]  idx;
    logic [2:0]  idx_nxt;
    logic [15:0] stall;
    logic        timeout_hit;

    assign idx_nxt = idx + 3'd1;
    // True on the stalled edge that brings the counter up to TIMEOUT.
    assign timeout_hit = (TIMEOUT != 16'd0) && (stall == TIMEOUT - 16'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            idx            <= 3'd0;
            stall          <= 16'd0;
            link.req_ready <= 1'b1;
            link.tx_valid  <= 1'b0;
            link.tx_data   <= 8'h00;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (link.req_valid) begin
                        frame[0]       <= HEAD;
                        frame[1]       <= link.req_addr;
                        frame[2]       <= {5'b0, link.req_func};
                        frame[3]       <= link.req_data[15:8];
                        frame[4]       <= link.req_data[7:0];
                        frame[5]       <= frame_checksum(link.req_addr, link.req_func, link.req_data);
                        idx            <= 3'd0;
                        stall          <= 16'd0;
                        link.tx_data   <= HEAD;
                        link.tx_valid  <= 1'b1;
                        link.req_ready <= 1'b0;
                        busy           <= 1'b1;
                        state          <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // A handshake takes priority over a coincident timeout.
                    if (link.tx_ready) begin
                        stall <= 16'd0;
                        if (idx == LAST_IDX) begin
                            link.tx_valid  <= 1'b0;
                            link.tx_data   <= 8'h00;
                            link.req_ready <= 1'b1;
                            busy           <= 1'b0;
                            done           <= 1'b1;
                            state          <= ST_IDLE;
                        end else begin
                            idx          <= idx_nxt;
                            link.tx_data <= frame[idx_nxt];
                        end
                    end else if (timeout_hit) begin
                        stall          <= 16'd0;
                        link.tx_valid  <= 1'b0;
                        link.tx_data   <= 8'h00;
                        link.req_ready <= 1'b1;
                        busy           <= 1'b0;
                        err            <= 1'b1;
                        state          <= ST_IDLE;
                    end else begin
                        stall <= stall + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_resp_frame_tx.sv
// Scoreboard bench for resp_frame_tx: expected frame bytes are queued when a
// request is driven and consumed on every tx handshake.
module tb_resp_frame_tx;

    logic clk;
    logic rst;
    logic busy;
    logic done;
    logic err;

    resp_frame_tx_if link ();

    resp_frame_tx #(
        .HEAD    (8'hF0),
        .TIMEOUT (16'd8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .link (link),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] sb [$];
    int         hs_total    = 0;
    int         hs_base     = 0;
    int         done_total  = 0;
    int         ready_mode  = 0;   // 0: always ready, 1: toggle, 2: ready for stall_after bytes
    int         stall_after = 6;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] a, input logic [2:0] f, input logic [15:0] d);
        logic [7:0] fb;
        fb = {5'b0, f};
        sb.push_back(8'hF0);
        sb.push_back(a);
        sb.push_back(fb);
        sb.push_back(d[15:8]);
        sb.push_back(d[7:0]);
        sb.push_back(a ^ fb ^ d[15:8] ^ d[7:0]);
    endtask

    // Returns just after the accepting edge, so the next negedge shows byte0.
    task automatic send_req(input logic [7:0] a, input logic [2:0] f, input logic [15:0] d);
        int n = 0;
        @(negedge clk);
        while (!link.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", link.req_ready, 1'b1);
        link.req_addr  = a;
        link.req_func  = f;
        link.req_data  = d;
        link.req_valid = 1'b1;
        push_frame(a, f, d);
        @(posedge clk);
        #1 link.req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        @(negedge clk);
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, done, 1'b1);
        chk("sb_drained", sb.size(), 0);
    endtask

    // tx_ready driver
    initial begin
        link.tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       link.tx_ready = 1'b1;
                1:       link.tx_ready = ~link.tx_ready;
                default: link.tx_ready = ((hs_total - hs_base) < stall_after);
            endcase
        end
    end

    // Output monitor: scoreboard pop on handshake, hold check while stalled.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        logic [7:0] exp_b;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (prev_stall && !err) begin
                chk("hold_valid", link.tx_valid, 1'b1);
                chk("hold_data", link.tx_data, prev_data);
            end
            if (link.tx_valid && link.tx_ready && !rst) begin
                hs_total++;
                if (sb.size() == 0) begin
                    chk("sb_underrun", sb.size(), 1);
                end else begin
                    exp_b = sb.pop_front();
                    chk("tx_byte", link.tx_data, exp_b);
                end
            end
            if (done) done_total++;
            prev_stall = link.tx_valid && !link.tx_ready && !rst;
            prev_data  = link.tx_data;
        end
    end

    initial begin
        logic [7:0] t1_bytes [6];
        int         n;
        int         stalls;
        int         done_before;

        t1_bytes = '{8'hF0, 8'h03, 8'h01, 8'h00, 8'h05, 8'h07};
        rst            = 1'b1;
        link.req_valid = 1'b0;
        link.req_addr  = 8'h00;
        link.req_func  = 3'd0;
        link.req_data  = 16'h0000;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_req_ready", link.req_ready, 1'b1);
        chk("rst_tx_valid", link.tx_valid, 1'b0);
        chk("rst_tx_data", link.tx_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);

        // 1: back-to-back bytes, then done
        ready_mode = 0;
        send_req(8'h03, 3'd1, 16'h0005);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t1_valid", link.tx_valid, 1'b1);
            chk("t1_byte", link.tx_data, t1_bytes[i]);
            chk("t1_busy", busy, 1'b1);
        end
        @(negedge clk);
        chk("t1_done", done, 1'b1);
        chk("t1_idle_valid", link.tx_valid, 1'b0);
        chk("t1_idle_ready", link.req_ready, 1'b1);
        chk("t1_idle_busy", busy, 1'b0);
        @(negedge clk);
        chk("t1_done_pulse", done, 1'b0);

        // 2: tx_ready toggling
        ready_mode = 1;
        send_req(8'h03, 3'd1, 16'h0005);
        wait_done("t2_done");
        @(negedge clk);

        // 3: back-to-back requests, request during frame ignored
        ready_mode = 0;
        send_req(8'h03, 3'd4, 16'h0000);
        link.req_addr  = 8'h55;
        link.req_func  = 3'd7;
        link.req_data  = 16'hFFFF;
        link.req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_ready_low", link.req_ready, 1'b0);
        end
        link.req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t3_done1", done, 1'b1);
        chk("t3_gap_ready", link.req_ready, 1'b1);
        link.req_addr  = 8'h03;
        link.req_func  = 3'd2;
        link.req_data  = 16'h0100;
        link.req_valid = 1'b1;
        push_frame(8'h03, 3'd2, 16'h0100);
        @(posedge clk);
        #1 link.req_valid = 1'b0;
        @(negedge clk);
        chk("t3_next_valid", link.tx_valid, 1'b1);
        chk("t3_next_head", link.tx_data, 8'hF0);
        wait_done("t3_done2");

        // 4: timeout after byte1
        done_before = done_total;
        hs_base     = hs_total;
        stall_after = 2;
        ready_mode  = 2;
        send_req(8'h03, 3'd3, 16'hBEEF);
        stalls = 0;
        n = 0;
        @(negedge clk);
        while (!err && n < 40) begin
            if (link.tx_valid && !link.tx_ready) stalls++;
            @(negedge clk);
            n++;
        end
        chk("t4_err", err, 1'b1);
        chk("t4_stall_cycles", stalls, 8);
        chk("t4_valid_drop", link.tx_valid, 1'b0);
        chk("t4_no_done", done, 1'b0);
        chk("t4_ready", link.req_ready, 1'b1);
        chk("t4_sb_left", sb.size(), 4);
        sb.delete();
        @(negedge clk);
        chk("t4_err_pulse", err, 1'b0);
        chk("t4_done_count", done_total, done_before);
        ready_mode = 0;
        send_req(8'h03, 3'd3, 16'h1234);
        wait_done("t4_restart_done");

        // 5: reset while byte3 is stalled
        hs_base     = hs_total;
        stall_after = 3;
        ready_mode  = 2;
        send_req(8'h03, 3'd3, 16'h1234);
        n = 0;
        @(negedge clk);
        while (!(link.tx_valid && !link.tx_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5_byte3", link.tx_data, 8'h12);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_valid", link.tx_valid, 1'b0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_ready", link.req_ready, 1'b1);
        chk("t5_sb_left", sb.size(), 3);
        sb.delete();
        ready_mode = 0;
        send_req(8'h03, 3'd2, 16'h0A0B);
        wait_done("t5_clean_done");

        // 6: inputs change mid-frame; unvalidated func code
        ready_mode = 1;
        send_req(8'h03, 3'd3, 16'hA55A);
        link.req_addr = 8'h77;
        link.req_func = 3'd5;
        link.req_data = 16'h0F0F;
        wait_done("t6_done");
        ready_mode = 0;
        send_req(8'h81, 3'd7, 16'hFFFF);
        link.req_data = 16'h0000;
        wait_done("t6_func7_done");

        repeat (3) @(negedge clk);
        chk("final_sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
